// File: rtl/shift_reg_194_pkg.sv
// Shared definitions for the 74x194-style universal shift register.
//   MODE_*            : encodings of the S mode-select input
//   WIDTH_MIN/MAX     : legal range of the WIDTH parameter
//   mode_is_legal_width() : helper used by the elaboration-time width check
package shift_reg_194_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    function automatic bit mode_is_legal_width(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/shift_reg_194_dff_cell_cr.sv
// One-bit negative-edge D storage cell with asynchronous active-low clear.
// Behaves like the master-slave trigger cell: the value on D is captured on
// the falling edge of CP, and a rising edge never changes Q.
//   CP   : clock, captures on the falling edge
//   CR_N : asynchronous clear, active-low, forces Q=0
//   D    : data in
//   Q    : stored bit
//   QN   : complement of Q
module dff_cell_cr (
    input  logic CP,
    input  logic CR_N,
    input  logic D,
    output logic Q,
    output logic QN
);

    always_ff @(negedge CP or negedge CR_N) begin
        if (!CR_N) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end

    assign QN = ~Q;

endmodule

// File: rtl/shift_reg_194.sv
// Universal bidirectional shift register, 74x194 function.
// Each bit is a dff_cell_cr; this level supplies the per-bit 4-way mode mux.
//   CP   : clock, state updates on the falling edge
//   CR_N : asynchronous clear, active-low, overrides every mode
//   S    : mode select (HOLD / SHR / SHL / LOAD)
//   DSR  : serial input entering Q[0] when shifting right
//   DSL  : serial input entering Q[WIDTH-1] when shifting left
//   D    : parallel load data
//   Q    : register contents; serial outputs are Q[WIDTH-1] (SHR) and Q[0] (SHL)
//   ZERO : high when Q is all zeros, combinational from Q
module shift_reg_194
    import shift_reg_194_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             CR_N,
    input  logic [1:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             ZERO
);

    generate
        if (!mode_is_legal_width(WIDTH)) begin : g_bad_width
            $error("shift_reg_194: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    // Shifted views of Q with the serial inputs spliced in at the end bits,
    // so every bit's mux is uniform and never indexes past the vector.
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] qn_bus;

    assign shr_vec = {Q[WIDTH-2:0], DSR};
    assign shl_vec = {DSL, Q[WIDTH-1:1]};

    always_comb begin
        nxt = Q;
        unique case (S)
            MODE_HOLD: nxt = Q;
            MODE_SHR:  nxt = shr_vec;
            MODE_SHL:  nxt = shl_vec;
            MODE_LOAD: nxt = D;
            default:   nxt = Q;
        endcase
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            dff_cell_cr u_cell (
                .CP   (CP),
                .CR_N (CR_N),
                .D    (nxt[i]),
                .Q    (Q[i]),
                .QN   (qn_bus[i])
            );
        end
    endgenerate

    // All complements high means all bits low.
    assign ZERO = &qn_bus;

endmodule

// File: tb/tb_shift_reg_194.sv
module tb_shift_reg_194;

    localparam int W = 4;

    logic         cp;
    logic         cr_n;
    logic [1:0]   s;
    logic         dsr_drv;
    logic         dsr_w;
    logic         dsl;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         zero;
    logic         johnson;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] mq;   // reference model of the register contents

    assign dsr_w = johnson ? ~q[W-1] : dsr_drv;

    shift_reg_194 #(.WIDTH(W)) dut (
        .CP   (cp),
        .CR_N (cr_n),
        .S    (s),
        .DSR  (dsr_w),
        .DSL  (dsl),
        .D    (d),
        .Q    (q),
        .ZERO (zero)
    );

    initial cp = 1'b1;
    always #5 cp = ~cp;

    // Reference next state from the function table, using plain arithmetic.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic [1:0] mode,
                                                input logic [W-1:0] din, input logic sr, input logic sl);
        int v;
        v = int'(cur);
        case (mode)
            2'd1:    v = ((v * 2) + int'(sr)) % (1 << W);
            2'd2:    v = (v / 2) + int'(sl) * (1 << (W - 1));
            2'd3:    v = int'(din);
            default: v = v;
        endcase
        return v[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_both(input string tag);
        chk(tag, q, mq);
        chk({tag, "_zero"}, {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, (mq == '0)});
    endtask

    // Drive inputs while CP is high, let the falling edge act, check after it.
    task automatic step(input logic [1:0] s_i, input logic [W-1:0] d_i,
                        input logic sr_i, input logic sl_i, input string tag);
        logic sr_eff;
        @(posedge cp);
        #1;
        s = s_i; d = d_i; dsr_drv = sr_i; dsl = sl_i;
        @(negedge cp);
        sr_eff = johnson ? ~mq[W-1] : sr_i;
        if (cr_n) mq = model_next(mq, s_i, d_i, sr_eff, sl_i);
        else      mq = '0;
        #1;
        chk_both(tag);
    endtask

    initial begin
        cr_n = 1'b0; s = 2'b00; d = '0; dsr_drv = 1'b0; dsl = 1'b0; johnson = 1'b0;
        mq = '0;

        // Reset held low: edges ignored even in LOAD mode.
        #2;
        chk_both("reset_state");
        step(2'b11, 4'b1111, 1'b0, 1'b0, "reset_held_load");

        @(posedge cp); #1 cr_n = 1'b1;
        step(2'b11, 4'b1011, 1'b0, 1'b0, "load_1011");

        // Clear pulse while CP is high clears before the next edge.
        @(posedge cp); #2 cr_n = 1'b0;
        mq = '0;
        #1 chk_both("async_clear_mid_cycle");

        // Release just at the falling edge with LOAD 1111 pending: that edge is lost.
        s = 2'b11; d = 4'b1111;
        @(negedge cp); #1 cr_n = 1'b1;
        mq = '0;
        chk_both("release_edge_ignored");
        step(2'b11, 4'b1111, 1'b0, 1'b0, "first_edge_after_release");

        // LOAD then HOLD; rising edge must not change Q.
        step(2'b11, 4'b0110, 1'b0, 1'b0, "load_0110");
        for (int i = 0; i < 3; i++) step(2'b00, 4'b1001, 1'b1, 1'b1, "hold");
        @(posedge cp); #1 chk_both("rising_edge_no_change");

        // SHR serial in 1,0,1,1.
        step(2'b11, 4'b0000, 1'b0, 1'b0, "clear_by_load");
        begin
            logic [3:0] bits;
            bits = 4'b1101;   // applied LSB first: 1,0,1,1
            for (int i = 0; i < 4; i++) step(2'b01, 4'b1111, bits[i], 1'b0, "shr_serial");
            chk("shr_final_1011", q, 4'b1011);
            // SHL serial in 1,1,0,1.
            step(2'b11, 4'b0000, 1'b0, 1'b0, "clear_by_load");
            bits = 4'b1011;   // applied LSB first: 1,1,0,1
            for (int i = 0; i < 4; i++) step(2'b10, 4'b1111, 1'b0, bits[i], "shl_serial");
            chk("shl_final_1011", q, 4'b1011);
        end

        // Johnson counter with external feedback, two full periods.
        step(2'b11, 4'b0000, 1'b0, 1'b0, "clear_by_load");
        johnson = 1'b1;
        for (int i = 0; i < 16; i++) step(2'b01, 4'b0000, 1'b0, 1'b0, "johnson");
        chk("johnson_wrap_0000", q, 4'b0000);
        johnson = 1'b0;

        // Mode change on every edge.
        step(2'b11, 4'b1001, 1'b0, 1'b0, "switch_load");
        step(2'b01, 4'b0000, 1'b0, 1'b0, "switch_shr");
        step(2'b10, 4'b0000, 1'b0, 1'b1, "switch_shl");
        step(2'b00, 4'b0000, 1'b0, 1'b0, "switch_hold");

        // Random stimulus with occasional mid-cycle clears.
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 19) == 0) begin
                @(posedge cp); #1 s = 2'b00;
                #1 cr_n = 1'b0;
                mq = '0;
                #1 chk_both("random_clear");
                #1 cr_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
